fetch_sequencer: RTL and testbench

//  Sequences instruction fetch between the program counter and the instruction bus.

---
 rtl/fetch_sequencer.sv | 112 +++++++++++
 tb/tb_fetch_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: picks the next fetch address (flush > branch > sequential) and runs one I-bus transaction at a time into a decode holding register
// Ports: clk/rst (async, active-low); stall, flush/flush_pc, br_flag/br_addr, usermode from the pipeline;
// ibus_req/ibus_addr out, ibus_addr_ok/ibus_data_ok/ibus_rdata in; inst_valid/inst/inst_pc/inst_excp to decode; fetch_busy.
module fetch_sequencer #(
  parameter logic [31:0] ENTRY_START = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_flag,
  input  logic [31:0] br_addr,
  input  logic        usermode,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_addr_ok,
  input  logic        ibus_data_ok,
  input  logic [31:0] ibus_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_excp,
  output logic        fetch_busy
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD, S_OUT} state_t;
  state_t r_state, w_state;
  logic [31:0] r_pc, w_pc, r_addr, w_addr, r_inst, w_inst, r_inst_pc, w_inst_pc;
  logic r_valid, w_valid, r_excp, w_excp, r_pend, w_pend;
  logic w_redir, w_launch, w_bad;
  logic [31:0] w_target, w_la;
  assign w_redir = flush | (br_flag & ~stall);
  assign w_target = flush ? flush_pc : br_addr;
  // whenever a launch happens this cycle, a redirect target beats the stored pc
  assign w_la = w_redir ? w_target : r_pc;
  assign w_bad = (w_la[1:0] != 2'b00) || (usermode && w_la[31]);
  assign ibus_req = r_state == S_REQ;
  assign ibus_addr = r_addr;
  assign inst_valid = r_valid;
  assign inst = r_inst;
  assign inst_pc = r_inst_pc;
  assign inst_excp = r_excp;
  assign fetch_busy = r_state == S_WAIT || r_state == S_DISCARD;
  always_comb begin
    w_state = r_state;
    w_pc = w_redir ? w_target : r_pc;
    w_addr = r_addr;
    w_inst = r_inst;
    w_inst_pc = r_inst_pc;
    w_valid = r_valid;
    w_excp = r_excp;
    w_pend = r_pend;
    w_launch = 1'b0;
    case (r_state)
      S_IDLE: w_launch = 1'b1;
      S_REQ: begin
        // the request cannot be retracted; a redirect only marks its response as stale
        if (ibus_addr_ok) w_state = (r_pend || w_redir) ? S_DISCARD : S_WAIT;
        else if (w_redir) w_pend = 1'b1;
      end
      S_WAIT: begin
        if (w_redir) begin
          w_launch = ibus_data_ok;
          w_state = S_DISCARD;
        end else if (ibus_data_ok) begin
          w_inst = ibus_rdata;
          w_inst_pc = r_addr;
          w_excp = 1'b0;
          w_valid = 1'b1;
          w_pc = r_addr + 32'd4;
          w_state = S_OUT;
        end
      end
      S_DISCARD: begin
        w_launch = ibus_data_ok;
        w_pend = ibus_data_ok ? 1'b0 : r_pend;
      end
      S_OUT: w_launch = w_redir || !stall;
      default: w_state = S_IDLE;
    endcase
    // misaligned or user-mode kernel fetch skips the bus and presents an AdEL slot directly
    if (w_launch) begin
      w_valid = w_bad;
      w_state = w_bad ? S_OUT : S_REQ;
      w_addr = w_bad ? r_addr : w_la;
      w_inst = w_bad ? 32'h0 : r_inst;
      w_inst_pc = w_bad ? w_la : r_inst_pc;
      w_excp = w_bad ? 1'b1 : r_excp;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc <= ENTRY_START;
      r_addr <= ENTRY_START;
      r_inst <= 32'h0;
      r_inst_pc <= 32'h0;
      r_valid <= 1'b0;
      r_excp <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc <= w_pc;
      r_addr <= w_addr;
      r_inst <= w_inst;
      r_inst_pc <= w_inst_pc;
      r_valid <= w_valid;
      r_excp <= w_excp;
      r_pend <= w_pend;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed per-cycle vectors against fetch_sequencer with a one-outstanding bus responder
module tb_fetch_sequencer;
  localparam logic [31:0] K = 32'h1234_5678;
  localparam logic O = 1'b0, I = 1'b1;
  localparam logic [31:0] Z = 32'h0, E0 = 32'hBFC0_0000, E4 = 32'hBFC0_0004, E8 = 32'hBFC0_0008;
  localparam logic [31:0] B100 = 32'hBFC0_0100, B104 = 32'hBFC0_0104, B108 = 32'hBFC0_0108, B200 = 32'hBFC0_0200;
  localparam logic [31:0] F380 = 32'hBFC0_0380, B102 = 32'hBFC0_0102, K80 = 32'h8000_0000, TOP = 32'hFFFF_FFFC;
  typedef struct packed {
    logic st, fl;
    logic [31:0] fpc;
    logic br;
    logic [31:0] ba;
    logic um, aen, den, e_req;
    logic [31:0] e_addr;
    logic e_val;
    logic [31:0] e_ipc;
    logic e_exc, e_busy;
  } vec_t;
  logic clk = 1'b0, rst;
  logic stall, flush, br_flag, usermode, ibus_addr_ok, ibus_data_ok;
  logic [31:0] flush_pc, br_addr, ibus_rdata;
  logic ibus_req, inst_valid, inst_excp, fetch_busy;
  logic [31:0] ibus_addr, inst, inst_pc;
  logic aen, den, outst;
  logic [31:0] tr_addr;
  int checks = 0, errors = 0;
  vec_t tbl[22];
  fetch_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .br_flag(br_flag), .br_addr(br_addr), .usermode(usermode),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_addr_ok(ibus_addr_ok),
    .ibus_data_ok(ibus_data_ok), .ibus_rdata(ibus_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_excp(inst_excp),
    .fetch_busy(fetch_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    logic acc, dok;
    logic [31:0] a;
    acc = ibus_req && ibus_addr_ok;
    dok = ibus_data_ok;
    a = ibus_addr;
    @(posedge clk);
    #1;
    if (dok) outst = 1'b0;
    if (acc) begin
      outst = 1'b1;
      tr_addr = a;
    end
  endtask
  task automatic apply(input vec_t v, input string tag);
    stall = v.st; flush = v.fl; flush_pc = v.fpc; br_flag = v.br; br_addr = v.ba;
    usermode = v.um; aen = v.aen; den = v.den;
    ibus_addr_ok = ibus_req && !outst && aen;
    ibus_data_ok = outst && den;
    ibus_rdata = ibus_data_ok ? tr_addr ^ K : 32'h0;
    chk({tag, ".req"}, {31'b0, ibus_req}, {31'b0, v.e_req});
    if (v.e_req) chk({tag, ".addr"}, ibus_addr, v.e_addr);
    chk({tag, ".valid"}, {31'b0, inst_valid}, {31'b0, v.e_val});
    chk({tag, ".busy"}, {31'b0, fetch_busy}, {31'b0, v.e_busy});
    if (v.e_val) begin
      chk({tag, ".inst_pc"}, inst_pc, v.e_ipc);
      chk({tag, ".inst"}, inst, v.e_exc ? 32'h0 : v.e_ipc ^ K);
      chk({tag, ".excp"}, {31'b0, inst_excp}, {31'b0, v.e_exc});
    end
    tick();
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".req"}, {31'b0, ibus_req}, 32'h0);
    chk({tag, ".addr"}, ibus_addr, E0);
    chk({tag, ".valid"}, {31'b0, inst_valid}, 32'h0);
    chk({tag, ".inst"}, inst, 32'h0);
    chk({tag, ".inst_pc"}, inst_pc, 32'h0);
    chk({tag, ".excp"}, {31'b0, inst_excp}, 32'h0);
    chk({tag, ".busy"}, {31'b0, fetch_busy}, 32'h0);
  endtask
  initial begin
    tbl = '{
      '{O,O,Z,O,Z,O,I,I, O,E0,O,Z,O,O},
      '{O,O,Z,O,Z,O,I,I, I,E0,O,Z,O,O},
      '{O,O,Z,O,Z,O,I,I, O,Z,O,Z,O,I},
      '{O,O,Z,O,Z,O,I,I, O,Z,I,E0,O,O},
      '{O,O,Z,O,Z,O,I,I, I,E4,O,Z,O,O},
      '{O,O,Z,O,Z,O,I,I, O,Z,O,Z,O,I},
      '{I,O,Z,O,Z,O,I,I, O,Z,I,E4,O,O},
      '{I,O,Z,O,Z,O,I,I, O,Z,I,E4,O,O},
      '{I,O,Z,O,Z,O,I,I, O,Z,I,E4,O,O},
      '{I,O,Z,O,Z,O,I,I, O,Z,I,E4,O,O},
      '{I,O,Z,O,Z,O,I,I, O,Z,I,E4,O,O},
      '{O,O,Z,O,Z,O,I,I, O,Z,I,E4,O,O},
      '{O,O,Z,O,Z,O,I,I, I,E8,O,Z,O,O},
      '{O,O,Z,I,B100,O,I,O, O,Z,O,Z,O,I},
      '{O,O,Z,O,Z,O,I,I, O,Z,O,Z,O,I},
      '{O,O,Z,O,Z,O,I,I, I,B100,O,Z,O,O},
      '{O,O,Z,O,Z,O,I,I, O,Z,O,Z,O,I},
      '{O,O,Z,O,Z,O,I,I, O,Z,I,B100,O,O},
      '{O,O,Z,O,Z,O,I,I, I,B104,O,Z,O,O},
      '{I,O,Z,I,B200,O,I,I, O,Z,O,Z,O,I},
      '{I,O,Z,O,Z,O,I,I, O,Z,I,B104,O,O},
      '{O,O,Z,O,Z,O,I,I, O,Z,I,B104,O,O}
    };
    rst = 1'b0; stall = 1'b0; flush = 1'b0; br_flag = 1'b0; usermode = 1'b0;
    flush_pc = 32'h0; br_addr = 32'h0; ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0; ibus_rdata = 32'h0;
    aen = 1'b0; den = 1'b0; outst = 1'b0; tr_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;
    for (int i = 0; i < 22; i++) apply(tbl[i], $sformatf("row%0d", i));
    apply('{O,I,F380,I,B100,O,O,I, I,B108,O,Z,O,O}, "flush_req");
    apply('{O,O,Z,O,Z,O,O,I, I,B108,O,Z,O,O}, "flush_hold1");
    apply('{O,O,Z,O,Z,O,O,I, I,B108,O,Z,O,O}, "flush_hold2");
    apply('{O,O,Z,O,Z,O,I,I, I,B108,O,Z,O,O}, "flush_aok");
    apply('{O,O,Z,O,Z,O,I,I, O,Z,O,Z,O,I}, "flush_discard");
    apply('{O,O,Z,O,Z,O,I,I, I,F380,O,Z,O,O}, "flush_target");
    apply('{O,O,Z,O,Z,O,I,I, O,Z,O,Z,O,I}, "flush_wait");
    apply('{O,O,Z,I,B102,O,I,I, O,Z,I,F380,O,O}, "flush_out");
    apply('{O,O,Z,I,K80,I,I,I, O,Z,I,B102,I,O}, "misalign");
    apply('{O,O,Z,I,TOP,O,I,I, O,Z,I,K80,I,O}, "user_kseg");
    apply('{O,O,Z,O,Z,O,I,I, I,TOP,O,Z,O,O}, "wrap_req");
    apply('{O,O,Z,O,Z,O,I,I, O,Z,O,Z,O,I}, "wrap_wait");
    apply('{O,O,Z,O,Z,O,I,I, O,Z,I,TOP,O,O}, "wrap_out");
    apply('{O,O,Z,O,Z,O,I,O, I,Z,O,Z,O,O}, "wrap_next");
    chk("pre_rst.busy", {31'b0, fetch_busy}, 32'h1);
    rst = 1'b0;
    #1;
    chk_reset("mid_rst");
    outst = 1'b0; ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply('{O,O,Z,O,Z,O,I,I, O,E0,O,Z,O,O}, "restart_idle");
    apply('{O,O,Z,O,Z,O,I,I, I,E0,O,Z,O,O}, "restart_req");
    apply('{O,O,Z,O,Z,O,I,I, O,Z,O,Z,O,I}, "restart_wait");
    apply('{O,O,Z,O,Z,O,I,I, O,Z,I,E0,O,O}, "restart_out");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
